jtag_tap_master: RTL and testbench
==================================

Name: jtag_tap_master

Overview:
- Initiator-side JTAG TAP sequencer. Generates tck/tms/tdi from the system clock and samples tdo.
- Lets on-chip logic (test harness, scan bring-up controller) drive IR/DR scans into any 1149.1 TAP, including the CPU debug TAP chain.
- Accepts one command at a time over a valid/ready interface and returns captured tdo bits as a single-cycle response.

Parameters:
- MAX_LEN, 38, max scan length in bits; width of cmd_data/rsp_data.
- LEN_W, 6, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN.
- CLK_DIV, 2, clk cycles per tck half-period; legal range ≥1.

Ports:
- clk  in  1  system clock, sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 DR scan; 01 IR scan; 10 TAP reset; 11 run-idle for cmd_len tck cycles.
- cmd_len  in  LEN_W  scan length or idle count.
- cmd_data  in  MAX_LEN  tdi bits, bit 0 shifted first.
- rsp_valid  out  1  one-cycle pulse: command complete.
- rsp_data  out  MAX_LEN  captured tdo bits, bit 0 first captured; held until next rsp_valid.
- busy  out  1  high from reset through command completion.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1.
- TCK cycle:
  - Each tck cycle is 2*CLK_DIV clk cycles: low phase, then high phase.
  - tms/tdi update only on the clk edge that drives tck low (falling edge).
  - tdo is registered on the clk edge that drives tck high (rising edge).
  - tck idles low between commands.
- Init after reset release: auto TLR sequence of tms = 1,1,1,1,1,0 (6 tck cycles), leaving the TAP in Run-Test/Idle (RTI). Then busy=0 and cmd_ready=1; no rsp_valid is generated for init.
- Handshake:
  - Accept on the clk edge with cmd_valid & cmd_ready (cycle T). cmd_ready=0 and busy=1 from T+1.
  - The first tck low phase starts at T+1.
  - Inputs are captured at accept; later changes are ignored.
- FSM states: IDLE, PRE, SHIFT, POST, DONE. Per-op tms sequences:
  - DR: PRE tms 1,0,0 (Select-DR, Capture-DR, Shift-DR). SHIFT: N cycles, tms=0 except last=1 (Exit1-DR), tdi=cmd_data[i]. POST tms 1,0 (Update-DR, RTI). Total N+5 tck cycles.
  - IR: PRE tms 1,1,0,0; otherwise identical to DR. Total N+6 tck cycles.
  - TAP reset: tms 1,1,1,1,1,0. Total 6 tck cycles; cmd_len ignored.
  - Idle: N tck cycles with tms=0, tdi=0.
- tdi outside SHIFT is 0.
- tdo sampling: only on the N rising edges inside SHIFT; sample i goes to rsp_data[i]. Bits ≥N read 0; rsp_data is 0 for reset/idle ops.
- Completion:
  - After the last high phase ends, DONE lasts one clk cycle: rsp_valid=1, cmd_ready=1, busy=0, rsp_data updated.
  - Latency = 1 + 2*CLK_DIV*(tck cycles) clk cycles from accept to rsp_valid.
  - Back-to-back accept in the DONE cycle is legal.
- Boundaries:
  - cmd_len=0 with DR/IR/idle: no tck activity; rsp_valid at T+1 with rsp_data=0.
  - cmd_len>MAX_LEN: clamped to MAX_LEN.
  - N=1: the single SHIFT cycle carries tms=1.
  - Bit counter and divider use saturating compare, no wrap.
- Mid-operation reset: all outputs return to reset values immediately (tck may truncate). On release, the full init TLR sequence runs; any in-flight command is discarded with no response.

Test Plan:
- Reset release, CLK_DIV=2: tms sequence 1,1,1,1,1,0 over 24 clk cycles; cmd_ready rises at cycle 25; no rsp_valid.
- Loopback (tdo=tdi), DR scan, N=8, cmd_data=0xA5: tms per tck = 1,0,0,0×7,1,1,0; rsp_valid exactly 53 clk after accept; rsp_data=0x0A5.
- IR scan, N=4, data=0x6, into a behavioural TAP model (IR capture 0001): rsp_data=0x1; model IR=0x6 after Update-IR; 10 tck cycles total.
- DR scan N=38, data all ones, into a model in BYPASS with tdo preloaded 0: rsp_data = 0x3F_FFFF_FFFE (1-bit shift delay); bits ≥38 zero; N=40 behaves identically to N=38 (clamp).
- Edge cases:
  - cmd_len=0 DR: rsp_valid at T+1, tck stays 0.
  - N=1 DR: SHIFT tms=1; 6 tck cycles.
  - Idle N=3: three tck pulses, tms=0.
- Reset asserted mid-SHIFT (bit 5 of 16): tck=0, tms=1, cmd_ready=0 asynchronously; after release, TLR init repeats; no rsp_valid for the aborted command; the next command completes normally.

Source files
------------

// File: rtl/jtag_tap_master.sv
// Initiator-side JTAG TAP sequencer: runs IR/DR scans, TAP resets and run-idle
// sequences from a valid/ready command and returns the captured tdo bits.
module jtag_tap_master #(
  parameter int MAX_LEN = 38,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] MAX_N    = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, DONE} state_e;
  typedef enum logic [1:0] {OP_DR, OP_IR, OP_RST, OP_RUN} op_e;

  state_e             state_q, state_d, seg_state;
  op_e                op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d, seg_cnt, pre_len, shift_len, len_clamp;
  logic [LEN_W:0]     cnt_inc;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, rsp_q, rsp_d;
  logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic               first_q, first_d, init_q, init_d;
  logic               phase_end, seg_tms;

  assign len_clamp = (cmd_len > MAX_N) ? MAX_N : cmd_len;
  assign cnt_inc   = {1'b0, cnt_q} + (LEN_W+1)'(1);
  assign phase_end = (div_q >= DIV_LAST);

  // Every command is PRE (fixed tms walk) + SHIFT (N data bits) + POST (Update, RTI);
  // TAP reset and run-idle are expressed purely as PRE walks.
  always_comb begin
    pre_len   = '0;
    shift_len = '0;
    unique case (op_q)
      OP_DR: begin
        if (len_q != '0) pre_len = LEN_W'(3);
        shift_len = len_q;
      end
      OP_IR: begin
        if (len_q != '0) pre_len = LEN_W'(4);
        shift_len = len_q;
      end
      OP_RST: pre_len = LEN_W'(6);
      OP_RUN: pre_len = len_q;
    endcase
  end

  // Segment and index of the tck cycle that starts at the next falling edge.
  always_comb begin
    seg_state = DONE;
    seg_cnt   = '0;
    if (first_q) begin
      if (pre_len != '0)        seg_state = PRE;
      else if (shift_len != '0) seg_state = SHIFT;
    end else begin
      case (state_q)
        PRE: begin
          if (cnt_inc < {1'b0, pre_len}) begin
            seg_state = PRE;
            seg_cnt   = cnt_inc[LEN_W-1:0];
          end else if (shift_len != '0) begin
            seg_state = SHIFT;
          end
        end
        SHIFT: begin
          seg_state = POST;
          if (cnt_inc < {1'b0, shift_len}) begin
            seg_state = SHIFT;
            seg_cnt   = cnt_inc[LEN_W-1:0];
          end
        end
        POST: begin
          if (cnt_q == '0) begin
            seg_state = POST;
            seg_cnt   = LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    seg_tms = 1'b0;
    case (seg_state)
      PRE: begin
        unique case (op_q)
          OP_DR:  seg_tms = (seg_cnt == '0);
          OP_IR:  seg_tms = (seg_cnt < LEN_W'(2));
          OP_RST: seg_tms = (seg_cnt < LEN_W'(5));
          OP_RUN: seg_tms = 1'b0;
        endcase
      end
      SHIFT:   seg_tms = (seg_cnt == shift_len - LEN_W'(1));
      POST:    seg_tms = (seg_cnt == '0);
      default: seg_tms = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    first_d = first_q;
    init_d  = init_q;
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    if (state_q == IDLE || state_q == DONE) begin
      state_d = IDLE;
      if (cmd_valid) begin
        op_d    = op_e'(cmd_op);
        len_d   = len_clamp;
        data_d  = cmd_data;
        cap_d   = '0;
        first_d = 1'b1;
        init_d  = 1'b0;
        cnt_d   = '0;
        div_d   = '0;
        state_d = PRE;
      end
    end else if (first_q || (tck_q && phase_end)) begin
      // Falling edge (or launch cycle): the only place tms/tdi change.
      first_d = 1'b0;
      tck_d   = 1'b0;
      div_d   = '0;
      cnt_d   = seg_cnt;
      tdi_d   = 1'b0;
      if (seg_state == DONE) begin
        state_d = init_q ? IDLE : DONE;
        tms_d   = 1'b0;
        if (!init_q) rsp_d = cap_q;
      end else begin
        state_d = seg_state;
        tms_d   = seg_tms;
        if (seg_state == SHIFT) tdi_d = data_q[seg_cnt];
      end
    end else if (!tck_q && phase_end) begin
      tck_d = 1'b1;
      div_d = '0;
      if (state_q == SHIFT) cap_d[cnt_q] = tdo;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Reset state doubles as a pending TLR walk so init reuses the command engine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PRE;
      first_q <= 1'b1;
      init_q  <= 1'b1;
      op_q    <= OP_RST;
      len_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      init_q  <= init_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) || (state_q == DONE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_tap_master.sv
// Scoreboard bench for jtag_tap_master: random commands into a behavioural
// 1149.1 target (or tdi->tdo loopback), expectations from scan-stream arithmetic.
module tb_jtag_tap_master;
  localparam int MAX_LEN = 38;
  localparam int LEN_W   = 6;
  localparam int CLK_DIV = 2;
  localparam logic [31:0] IDCODE = 32'h4BA0_0477;

  logic               clk, reset_n, cmd_valid, cmd_ready, rsp_valid, busy;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data, rsp_data;
  logic               tck, tms, tdi, tdo;

  jtag_tap_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural JTAG target ----------------
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_e;
  tap_e        tst = TLR;
  logic [3:0]  ir = 4'h1, ir_sh = 4'h0;
  logic [31:0] dr_sh = '0;
  logic        tap_tdo = 1'b0;
  bit          loop = 1'b0;
  logic        tms_hist[$];

  function automatic tap_e tnext(input tap_e s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PDR;
      PDR:   return m ? EX2DR : PDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PIR;
      PIR:   return m ? EX2IR : PIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    tms_hist.push_back(tms);
    case (tst)
      TLR:   ir = 4'h1;
      CAPIR: ir_sh = 4'b0001;
      SHIR:  ir_sh = {tdi, ir_sh[3:1]};
      UPIR:  ir = ir_sh;
      CAPDR: dr_sh = (ir == 4'hF) ? 32'h0 : IDCODE;
      SHDR:  if (ir == 4'hF) dr_sh[0] = tdi; else dr_sh = {tdi, dr_sh[31:1]};
      default: ;
    endcase
    tst = tnext(tst, tms);
  end

  always @(negedge tck)
    tap_tdo = (tst == SHIR) ? ir_sh[0] : (tst == SHDR) ? dr_sh[0] : 1'b0;

  assign tdo = loop ? tdi : tap_tdo;

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [MAX_LEN-1:0] rsp;
    logic [63:0]        tms;
    int                 ntck;
    int                 acc;
    logic [3:0]         ir;
  } exp_t;
  exp_t       sb[$];
  logic [3:0] exp_ir = 4'h1;

  // Scan result = first N bits of the stream {tdi data, captured register}.
  function automatic exp_t model(input logic [1:0] op, input int len,
                                 input logic [MAX_LEN-1:0] data, input bit lb);
    exp_t e;
    int n, k, reg_len;
    logic [127:0] s, m, cap;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    k = 0;
    e.tms = '0;
    e.rsp = '0;
    if (op == 2'd2) begin
      for (int i = 0; i < 6; i++) begin e.tms[k] = (i < 5); k++; end
      exp_ir = 4'h1;
    end else if (op == 2'd3) begin
      k = n;
    end else if (n > 0) begin
      if (op == 2'd1) begin
        reg_len = 4;  cap = 128'h1;
        e.tms[0] = 1'b1; e.tms[1] = 1'b1; k = 4;
      end else begin
        reg_len = (exp_ir == 4'hF) ? 1 : 32;
        cap     = (exp_ir == 4'hF) ? 128'h0 : 128'(IDCODE);
        e.tms[0] = 1'b1; k = 3;
      end
      for (int i = 0; i < n; i++) begin e.tms[k] = (i == n - 1); k++; end
      e.tms[k] = 1'b1; k = k + 2;
      s = (128'(data) << reg_len) | cap;
      m = (128'h1 << n) - 128'h1;
      e.rsp = MAX_LEN'(lb ? (128'(data) & m) : (s & m));
      if (op == 2'd1) exp_ir = 4'(s >> n);
    end
    e.ntck = k;
    e.ir   = exp_ir;
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input int len,
                       input logic [MAX_LEN-1:0] data, input bit lb);
    exp_t e;
    int w;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    w = 0;
    while (!cmd_ready && w < 3000) begin @(negedge clk); w++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    loop = lb;
    e = model(op, len, data, lb);
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = LEN_W'($urandom);
    cmd_data  = MAX_LEN'({$urandom(), $urandom()});
  endtask

  // Monitor: init check after each reset release, then one pop per rsp_valid.
  bit   init_chk = 1'b1, rel_seen = 1'b0;
  int   rel_cyc = 0, idx0 = 0;
  always @(negedge clk) begin
    exp_t        e;
    int          ng;
    logic [63:0] got;
    if (!reset_n) begin
      sb.delete();
      init_chk = 1'b1;
      rel_seen = 1'b0;
      idx0     = tms_hist.size();
    end else begin
      ng  = tms_hist.size() - idx0;
      got = '0;
      for (int k = 0; k < ng && k < 64; k++) got[k] = tms_hist[idx0 + k];
      if (init_chk) begin
        if (!rel_seen) begin rel_cyc = cyc; rel_seen = 1'b1; end
        if (rsp_valid) chk("init_no_rsp", rsp_valid, 0);
        if (cmd_ready) begin
          chk("init_cycles", cyc - rel_cyc, 1 + 2 * CLK_DIV * 6);
          chk("init_tck_count", ng, 6);
          chk("init_tms_seq", got, 64'b011111);
          chk("init_tap_rti", tst == RTI, 1);
          idx0     = tms_hist.size();
          init_chk = 1'b0;
        end else if (cyc - rel_cyc > 200) begin
          chk("init_timeout", 0, 1);
          init_chk = 1'b0;
        end
      end else if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.rsp);
          chk("latency", cyc - e.acc, 1 + 2 * CLK_DIV * e.ntck);
          chk("tck_count", ng, e.ntck);
          chk("tms_seq", got, e.tms);
          chk("tap_end_rti", tst == RTI, 1);
          chk("tap_ir", ir, e.ir);
        end
        idx0 = tms_hist.size();
      end
    end
  end

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || init_chk) && w < 5000) begin @(negedge clk); w++; end
    if (sb.size() != 0 || init_chk) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1);
  end

  initial begin
    int h0, w;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 1);
    @(posedge clk);
    #2 reset_n = 1'b1;

    issue(2'd0, 8,  MAX_LEN'(38'hA5), 1'b1);
    issue(2'd1, 4,  MAX_LEN'(38'h6), 1'b0);
    issue(2'd1, 4,  MAX_LEN'(38'hF), 1'b0);
    issue(2'd0, 38, '1, 1'b0);
    issue(2'd0, 40, '1, 1'b0);
    issue(2'd0, 0,  MAX_LEN'(38'h3C), 1'b1);
    issue(2'd1, 0,  MAX_LEN'(38'h3), 1'b0);
    issue(2'd0, 1,  MAX_LEN'(38'h1), 1'b1);
    issue(2'd3, 3,  '1, 1'b0);
    issue(2'd3, 0,  '1, 1'b0);
    issue(2'd2, 17, '1, 1'b0);
    issue(2'd0, 12, MAX_LEN'(38'h5A5), 1'b0);
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom_range(0, 45),
            MAX_LEN'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Abort a 16-bit DR scan while tck is high on shift bit 5.
    h0 = tms_hist.size();
    issue(2'd0, 16, MAX_LEN'(38'hBEEF), 1'b1);
    w = 0;
    while (tms_hist.size() < h0 + 9 && w < 500) begin @(negedge clk); w++; end
    if (tms_hist.size() < h0 + 9) chk("abort_wait_timeout", 0, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_tck", tck, 0);
    chk("abort_tms", tms, 1);
    chk("abort_tdi", tdi, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    chk("abort_busy", busy, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    exp_ir = 4'h1;
    issue(2'd0, 8, MAX_LEN'(38'h3C), 1'b1);
    issue(2'd0, 6, MAX_LEN'(38'h2A), 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
